uart_host_tx: RTL and testbench

UART_HOST_TX -- requirements
Module: uart_host_tx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 52 +++++
 rtl/uart_host_tx.sv | 144 ++++++++++++++
 tb/tb_uart_host_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- shared constants, frame state encoding and rate clamp for the host UART transmitter.
package uart_pkg;

  localparam logic [7:0]  SYNC_CHAR  = 8'h55;
  localparam int          FRAME_BITS = 10;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [15:0] MIN_RATE   = 16'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] eff_rate(input logic [15:0] r);
    return (r < MIN_RATE) ? MIN_RATE : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// uart_fifo -- 8-bit x 4 byte queue; full/empty come straight from the registered count,
// so a push in the same cycle as a pop on a full queue is still refused.
module uart_fifo
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       push,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'(FIFO_DEPTH));
  assign empty   = (count == 3'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_host_tx.sv
`default_nettype none
// uart_host_tx -- 8N1 serial transmitter with a 4-byte queue and an autobaud sync character
// that is sent first after reset and on request.
module uart_host_tx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rate,
  input  logic [7:0]  od,
  input  logic        dox,
  input  logic        sync,
  output logic        tx,
  output logic        full,
  output logic        wip
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_t   state, state_next;
  logic [15:0] rate_l, rate_l_next;
  logic [15:0] cnt, cnt_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        sync_pending, sync_pending_next;
  logic        tx_next;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        work;
  logic        bit_done;
  logic        start_frame;
  logic        take_sync;
  logic [15:0] rate_eff;

  uart_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (od),
    .push  (dox),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty)
  );

  assign work     = sync_pending || !fifo_empty;
  assign bit_done = (cnt == 16'd1);
  assign rate_eff = eff_rate(rate);
  assign wip      = (state != IDLE) || work;

  always_comb begin
    state_next   = state;
    rate_l_next  = rate_l;
    cnt_next     = cnt;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    tx_next      = tx;
    fifo_pop     = 1'b0;
    take_sync    = 1'b0;
    start_frame  = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (work) start_frame = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          cnt_next     = rate_l;
          bit_idx_next = 3'd0;
          tx_next      = shift[0];
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next = rate_l;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_done) begin
          if (work) start_frame = 1'b1;
          else      state_next  = IDLE;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A pending sync always wins over queued data; the bit period is frozen here for the whole frame.
    if (start_frame) begin
      state_next  = START;
      rate_l_next = rate_eff;
      cnt_next    = rate_eff;
      tx_next     = 1'b0;
      if (sync_pending) begin
        shift_next = SYNC_CHAR;
        take_sync  = 1'b1;
      end else begin
        shift_next = fifo_dout;
        fifo_pop   = 1'b1;
      end
    end

    sync_pending_next = take_sync ? 1'b0 : (sync_pending | sync);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rate_l       <= 16'd0;
      cnt          <= 16'd0;
      shift        <= 8'd0;
      bit_idx      <= 3'd0;
      sync_pending <= 1'b1;
      tx           <= 1'b1;
    end else begin
      state        <= state_next;
      rate_l       <= rate_l_next;
      cnt          <= cnt_next;
      shift        <= shift_next;
      bit_idx      <= bit_idx_next;
      sync_pending <= sync_pending_next;
      tx           <= tx_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_host_tx.sv
`default_nettype none
// tb_uart_host_tx -- directed and random stimulus; an edge-by-edge queue model of the line
// predicts every tx cycle, full and wip.
module tb_uart_host_tx;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rate  = 16'd16;
  logic [7:0]  od    = 8'd0;
  logic        dox   = 1'b0;
  logic        sync  = 1'b0;
  logic        tx;
  logic        full;
  logic        wip;

  uart_host_tx dut (
    .clk   (clk),
    .reset (reset),
    .rate  (rate),
    .od    (od),
    .dox   (dox),
    .sync  (sync),
    .tx    (tx),
    .full  (full),
    .wip   (wip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line model: byte queue, sync flag and the frame currently on the wire.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  int         sent_rate[$];
  bit         m_sync    = 1'b1;
  bit         m_active  = 1'b0;
  bit         pend_prev = 1'b0;
  int         m_pos     = 0;
  int         m_r       = 2;
  logic [9:0] m_bits    = '1;

  initial begin : model
    logic [7:0] b;
    bit accept, took_sync, in_frame;
    forever begin
      @(posedge clk);
      #1;
      in_frame = 1'b0;
      if (reset) begin
        chk_bit("tx_in_reset", tx, 1'b1);
        mq.delete();
        m_sync    = 1'b1;
        m_active  = 1'b0;
        pend_prev = 1'b1;
      end else begin
        accept    = dox && (mq.size() < 4);
        took_sync = 1'b0;
        in_frame  = 1'b1;
        if (m_active) begin
          chk_bit("tx_bit", tx, m_bits[m_pos / m_r]);
          m_pos++;
          if (m_pos == 10 * m_r) m_active = 1'b0;
        end else if (pend_prev) begin
          if (m_sync) begin
            b = 8'h55;
            took_sync = 1'b1;
            m_sync = 1'b0;
          end else begin
            b = mq.pop_front();
          end
          m_r      = (rate < 16'd2) ? 2 : int'(rate);
          m_bits   = {1'b1, b, 1'b0};
          m_pos    = 1;
          m_active = 1'b1;
          sent.push_back(b);
          sent_rate.push_back(m_r);
          chk_bit("tx_start", tx, 1'b0);
        end else begin
          chk_bit("tx_idle", tx, 1'b1);
          in_frame = 1'b0;
        end
        if (accept) mq.push_back(od);
        if (sync && !took_sync) m_sync = 1'b1;
        pend_prev = m_sync || (mq.size() != 0);
      end
      chk_bit("full", full, mq.size() == 4);
      chk_bit("wip", wip, in_frame || m_sync || (mq.size() != 0));
    end
  end

  task automatic pulse_dox(input logic [7:0] b);
    od  = b;
    dox = 1'b1;
    @(negedge clk);
    dox = 1'b0;
  endtask

  task automatic wait_quiet(input int bound);
    int n;
    n = 0;
    while ((m_active || m_sync || (mq.size() != 0)) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk_bit("quiet_in_time", n < bound, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pos(input int pos_min);
    int n;
    n = 0;
    while (!(m_active && m_pos >= pos_min) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_bit("reach_frame_pos", n < 2000, 1'b1);
  endtask

  initial begin : stim
    logic [7:0] bb[5];
    int f0;

    // Reset release and the automatic sync frame at rate 16.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_bit("wip_after_reset", wip, 1'b1);
    chk_bit("tx_after_reset", tx, 1'b1);
    chk_bit("full_after_reset", full, 1'b0);
    wait_quiet(2000);
    chk_bit("wip_idle", wip, 1'b0);
    chk_val("first_frame", 32'(sent[0]), 32'h55);
    chk_val("first_rate", sent_rate[0], 16);

    // Single byte: start bit two edges after the write.
    rate = 16'd8;
    pulse_dox(8'hA3);
    chk_bit("lat_edge1", tx, 1'b1);
    @(negedge clk);
    chk_bit("lat_edge2", tx, 1'b0);
    wait_quiet(1000);
    chk_val("a3_byte", 32'(sent[$]), 32'hA3);
    chk_val("a3_rate", sent_rate[$], 8);

    // Burst of five writes behind a frame in flight; the fifth is dropped.
    rate = 16'd5;
    pulse_dox(8'h3C);
    repeat (2) @(negedge clk);
    f0 = sent.size();
    for (int i = 0; i < 5; i++) begin
      bb[i] = 8'($urandom);
      od    = bb[i];
      dox   = 1'b1;
      @(negedge clk);
      if (i == 3) chk_bit("full_after_4th", full, 1'b1);
    end
    dox = 1'b0;
    chk_bit("full_after_5th", full, 1'b1);
    wait_quiet(2000);
    chk_val("burst_frames", sent.size() - f0, 4);
    for (int i = 0; i < 4; i++) chk_val("burst_order", 32'(sent[f0 + i]), 32'(bb[i]));

    // Three sync pulses mid-frame collapse into one sync frame ahead of the queue.
    rate = 16'd6;
    f0 = sent.size();
    for (int i = 0; i < 3; i++) begin
      bb[i] = 8'($urandom);
      od    = bb[i];
      dox   = 1'b1;
      @(negedge clk);
    end
    dox = 1'b0;
    wait_pos(9);
    for (int i = 0; i < 3; i++) begin
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      @(negedge clk);
    end
    wait_quiet(2000);
    chk_val("sync_frames", sent.size() - f0, 4);
    chk_val("sync_seq0", 32'(sent[f0]), 32'(bb[0]));
    chk_val("sync_seq1", 32'(sent[f0 + 1]), 32'h55);
    chk_val("sync_seq2", 32'(sent[f0 + 2]), 32'(bb[1]));
    chk_val("sync_seq3", 32'(sent[f0 + 3]), 32'(bb[2]));

    // Rate change mid-frame applies to the next frame; 0 and 1 clamp to 2.
    rate = 16'd10;
    f0 = sent.size();
    pulse_dox(8'($urandom));
    pulse_dox(8'($urandom));
    wait_pos(31);
    rate = 16'd20;
    wait_quiet(2000);
    chk_val("rate_cur", sent_rate[f0], 10);
    chk_val("rate_next", sent_rate[f0 + 1], 20);
    rate = 16'd0;
    pulse_dox(8'($urandom));
    wait_quiet(500);
    chk_val("rate_zero", sent_rate[$], 2);
    rate = 16'd1;
    pulse_dox(8'($urandom));
    wait_quiet(500);
    chk_val("rate_one", sent_rate[$], 2);

    // Reset during data bit 4 aborts the frame and empties the queue.
    rate = 16'd8;
    pulse_dox(8'($urandom));
    pulse_dox(8'($urandom));
    pulse_dox(8'($urandom));
    wait_pos(43);
    reset = 1'b1;
    @(negedge clk);
    chk_bit("tx_abort", tx, 1'b1);
    chk_bit("full_abort", full, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    chk_bit("wip_after_reset2", wip, 1'b1);
    f0 = sent.size();
    wait_quiet(2000);
    chk_val("frames_after_abort", sent.size() - f0, 1);
    chk_val("sync_after_abort", 32'(sent[$]), 32'h55);

    // Random traffic: writes, occasional sync requests and rate changes.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) rate = 16'($urandom_range(0, 5));
      od   = 8'($urandom);
      dox  = ($urandom_range(0, 3) == 0);
      sync = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    dox  = 1'b0;
    sync = 1'b0;
    wait_quiet(5000);
    chk_bit("tx_end", tx, 1'b1);
    chk_bit("wip_end", wip, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
